// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event strobes into fixed-width output pulses separated by a
// fixed minimum gap; events arriving mid-pulse are queued and replayed in order.
module pulse_stretcher #(
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 12_500_000,
  parameter int PEND_W      = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_pi,
  output logic              o_po,
  output logic              o_busy,
  output logic [PEND_W-1:0] o_pending,
  output logic              o_overflow
);

  localparam int MAXC  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC + 1) : 1;

  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [PEND_W-1:0] r_pend;
  logic [PEND_W-1:0] w_pend_nxt;
  logic              r_ovf;
  logic              w_ovf_nxt;
  logic              r_po;
  logic              w_last;
  logic              w_pend_full;

  assign w_last      = (r_cnt == '0);
  assign w_pend_full = (r_pend == PEND_MAX);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_ovf   <= 1'b0;
      r_po    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
      r_ovf   <= w_ovf_nxt;
      r_po    <= (w_state_nxt == S_HOLD);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      S_IDLE: begin
        if (i_pi) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = HOLD_LOAD;
        end
      end
      S_HOLD: begin
        if (w_last) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = GAP_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
        if (i_pi) begin
          if (w_pend_full) w_ovf_nxt = 1'b1;
          else             w_pend_nxt = r_pend + PEND_ONE;
        end
      end
      S_GAP: begin
        if (w_last) begin
          // A queued event takes priority; a same-cycle Pi then replaces the one consumed.
          if (r_pend != '0) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = HOLD_LOAD;
            if (!i_pi) w_pend_nxt = r_pend - PEND_ONE;
          end else if (i_pi) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = HOLD_LOAD;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
          if (i_pi) begin
            if (w_pend_full) w_ovf_nxt = 1'b1;
            else             w_pend_nxt = r_pend + PEND_ONE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_pend_nxt  = '0;
      end
    endcase
  end

  assign o_po       = r_po;
  assign o_busy     = (r_state != S_IDLE);
  assign o_pending  = r_pend;
  assign o_overflow = r_ovf;

endmodule
